// File: rtl/drawing_priority_mux_n_if.sv
// Pixel bus between the object drawers and the priority mux, plus the mux's
// colour and collision outputs toward the VGA stage and game logic.
interface drawing_priority_mux_n_if #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned COLOR_W    = 12
);
    localparam int unsigned NPAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;
    localparam int unsigned IDX_W  = $clog2(NUM_LAYERS + 1);
    localparam int unsigned CH_W   = COLOR_W / 3;

    logic [NUM_LAYERS-1:0]         layer_en;
    logic [NUM_LAYERS-1:0]         draw;
    logic [NUM_LAYERS*COLOR_W-1:0] RGB_in;
    logic [COLOR_W-1:0]            RGB_bg;
    logic                          pixel_valid;
    logic                          frame_start;

    logic [CH_W-1:0]               Red_level;
    logic [CH_W-1:0]               Green_level;
    logic [CH_W-1:0]               Blue_level;
    logic [IDX_W-1:0]              top_layer;
    logic                          collision_now;
    logic [NPAIRS-1:0]             collision_frame;
    logic                          collision_any;

    modport master (
        output layer_en, draw, RGB_in, RGB_bg, pixel_valid, frame_start,
        input  Red_level, Green_level, Blue_level, top_layer,
               collision_now, collision_frame, collision_any
    );

    modport slave (
        input  layer_en, draw, RGB_in, RGB_bg, pixel_valid, frame_start,
        output Red_level, Green_level, Blue_level, top_layer,
               collision_now, collision_frame, collision_any
    );
endinterface

// File: rtl/drawing_priority_mux_n.sv
// Two-stage N-layer pixel priority mux (layer 0 wins) with colour-key
// transparency and per-layer-pair collision flags latched once per frame.
module drawing_priority_mux_n #(
    parameter int unsigned        NUM_LAYERS = 4,
    parameter int unsigned        COLOR_W    = 12,
    parameter bit                 KEY_EN     = 1'b1,
    parameter logic [COLOR_W-1:0] KEY_COLOR  = '1
) (
    input logic                    clk,
    input logic                    reset,
    drawing_priority_mux_n_if.slave bus
);
    localparam int unsigned NPAIRS = NUM_LAYERS * (NUM_LAYERS - 1) / 2;
    localparam int unsigned IDX_W  = $clog2(NUM_LAYERS + 1);
    localparam int unsigned CH_W   = COLOR_W / 3;

    logic [NUM_LAYERS-1:0]         eff_c;
    logic [NUM_LAYERS-1:0]         eff_q;
    logic [NUM_LAYERS*COLOR_W-1:0] rgb_q;
    logic [COLOR_W-1:0]            bg_q;
    logic                          valid_q;
    logic                          fs_q;

    logic [COLOR_W-1:0]            sel_rgb_c;
    logic [IDX_W-1:0]              sel_idx_c;
    logic [NPAIRS-1:0]             hit_c;
    logic [NPAIRS-1:0]             sticky;

    // A layer counts only if drawn, enabled and not the transparent key colour
    always_comb begin
        eff_c = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            eff_c[i] = bus.draw[i] & bus.layer_en[i] &
                       ~(KEY_EN & (bus.RGB_in[i*COLOR_W +: COLOR_W] == KEY_COLOR));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eff_q   <= '0;
            rgb_q   <= '0;
            bg_q    <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            eff_q   <= eff_c;
            rgb_q   <= bus.RGB_in;
            bg_q    <= bus.RGB_bg;
            valid_q <= bus.pixel_valid;
            fs_q    <= bus.frame_start;
        end
    end

    // Scan from the lowest-priority layer down so the lowest index overwrites
    always_comb begin
        sel_rgb_c = bg_q;
        sel_idx_c = IDX_W'(NUM_LAYERS);
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (eff_q[i]) begin
                sel_rgb_c = rgb_q[i*COLOR_W +: COLOR_W];
                sel_idx_c = IDX_W'(i);
            end
        end
    end

    // Pair (i,j), i<j, maps to lexicographic index i*(2N-i-1)/2 + (j-i-1)
    for (genvar gi = 0; gi < NUM_LAYERS - 1; gi++) begin : g_row
        for (genvar gj = gi + 1; gj < NUM_LAYERS; gj++) begin : g_col
            localparam int unsigned PIDX = gi * (2 * NUM_LAYERS - gi - 1) / 2 + (gj - gi - 1);
            assign hit_c[PIDX] = eff_q[gi] & eff_q[gj] & valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.Red_level       <= '0;
            bus.Green_level     <= '0;
            bus.Blue_level      <= '0;
            bus.top_layer       <= IDX_W'(NUM_LAYERS);
            bus.collision_now   <= 1'b0;
            sticky              <= '0;
            bus.collision_frame <= '0;
            bus.collision_any   <= 1'b0;
        end else begin
            if (valid_q) begin
                bus.Red_level   <= sel_rgb_c[COLOR_W-1 -: CH_W];
                bus.Green_level <= sel_rgb_c[2*CH_W-1 -: CH_W];
                bus.Blue_level  <= sel_rgb_c[CH_W-1:0];
                bus.top_layer   <= sel_idx_c;
            end else begin
                bus.Red_level   <= '0;
                bus.Green_level <= '0;
                bus.Blue_level  <= '0;
                bus.top_layer   <= IDX_W'(NUM_LAYERS);
            end
            bus.collision_now <= |hit_c;
            // The frame_start pixel opens the new frame, so it is excluded from the latch
            if (fs_q) begin
                bus.collision_frame <= sticky;
                bus.collision_any   <= |sticky;
                sticky              <= hit_c;
            end else begin
                sticky              <= sticky | hit_c;
            end
        end
    end
endmodule

// File: tb/tb_drawing_priority_mux_n.sv
// Randomised and directed bench for drawing_priority_mux_n: a pixel-level
// reference model queues expected outputs, a monitor compares them on arrival.
module tb_drawing_priority_mux_n;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = 12;
    localparam int unsigned NP = 6;
    localparam int unsigned IW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    drawing_priority_mux_n_if #(.NUM_LAYERS(N), .COLOR_W(CW)) bus ();

    drawing_priority_mux_n #(
        .NUM_LAYERS(N), .COLOR_W(CW), .KEY_EN(1'b1), .KEY_COLOR(12'hFFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic [2:0]  top;
        logic        cnow;
        logic [5:0]  cf;
        logic        cany;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [NP-1:0] m_sticky = '0;
    logic [NP-1:0] m_cf     = '0;
    logic          m_cany   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every edge, compare whatever the model says must appear now
    always @(posedge clk) begin
        exp_t e;
        logic [11:0] got;
        #1;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e   = q.pop_front();
            got = {bus.Red_level, bus.Green_level, bus.Blue_level};
            checks++;
            if (e.due < cyc) begin
                errors++;
                $display("FAIL stale_entry cyc=%0d due=%0d", cyc, e.due);
            end else begin
                if (got !== e.rgb) begin
                    errors++;
                    $display("FAIL rgb cyc=%0d got %h exp %h", cyc, got, e.rgb);
                end
                checks++;
                if (bus.top_layer !== e.top) begin
                    errors++;
                    $display("FAIL top_layer cyc=%0d got %0d exp %0d", cyc, bus.top_layer, e.top);
                end
                checks++;
                if (bus.collision_now !== e.cnow) begin
                    errors++;
                    $display("FAIL collision_now cyc=%0d got %b exp %b", cyc, bus.collision_now, e.cnow);
                end
                checks++;
                if (bus.collision_frame !== e.cf) begin
                    errors++;
                    $display("FAIL collision_frame cyc=%0d got %b exp %b", cyc, bus.collision_frame, e.cf);
                end
                checks++;
                if (bus.collision_any !== e.cany) begin
                    errors++;
                    $display("FAIL collision_any cyc=%0d got %b exp %b", cyc, bus.collision_any, e.cany);
                end
            end
        end
    end

    function automatic logic [47:0] pack4(input logic [11:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    // Drive one pixel (or a reset cycle), queue its expected result, advance one clock
    task automatic step(input logic rs, input logic [3:0] en, input logic [3:0] dr,
                        input logic [47:0] rgb, input logic [11:0] bg,
                        input logic v, input logic fs);
        exp_t        e;
        logic [3:0]  eff;
        logic [NP-1:0] hits;
        int          win;
        int          p;
        reset           = rs;
        bus.layer_en    = en;
        bus.draw        = dr;
        bus.RGB_in      = rgb;
        bus.RGB_bg      = bg;
        bus.pixel_valid = v;
        bus.frame_start = fs;
        if (rs) begin
            while (q.size() > 0 && q[q.size()-1].due >= cyc + 1) void'(q.pop_back());
            m_sticky = '0;
            m_cf     = '0;
            m_cany   = 1'b0;
            e = '{due: cyc + 1, rgb: 12'h000, top: 3'(N), cnow: 1'b0, cf: 6'b0, cany: 1'b0};
            q.push_back(e);
            e.due = cyc + 2;
            q.push_back(e);
        end else begin
            for (int i = 0; i < int'(N); i++)
                eff[i] = dr[i] && en[i] && (rgb[i*12 +: 12] != 12'hFFF);
            win = N;
            for (int i = 0; i < int'(N); i++)
                if (eff[i] && win == int'(N)) win = i;
            hits = '0;
            p = 0;
            for (int i = 0; i < int'(N); i++)
                for (int j = i + 1; j < int'(N); j++) begin
                    hits[p] = eff[i] && eff[j] && v;
                    p++;
                end
            if (fs) begin
                m_cf     = m_sticky;
                m_cany   = |m_sticky;
                m_sticky = hits;
            end else begin
                m_sticky = m_sticky | hits;
            end
            e.due  = cyc + 2;
            e.rgb  = !v ? 12'h000 : (win < int'(N) ? rgb[win*12 +: 12] : bg);
            e.top  = v ? 3'(win) : 3'(N);
            e.cnow = |hits;
            e.cf   = m_cf;
            e.cany = m_cany;
            q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [47:0] rr;
        logic [3:0]  ee;
        logic [11:0] cc [4];
        // Reset held 3 clocks with every layer drawing
        repeat (3) step(1, 4'hF, 4'hF, pack4(12'h111, 12'h222, 12'h333, 12'h444), 12'h555, 1, 0);
        // Priority: layer 1 beats layer 2 and they collide
        step(0, 4'hF, 4'b0110, pack4(12'h111, 12'h0F0, 12'hF00, 12'h222), 12'h000, 1, 0);
        // Colour key makes layer 0 transparent, background shows
        step(0, 4'hF, 4'b0001, pack4(12'hFFF, 12'h0F0, 12'hF00, 12'h222), 12'h123, 1, 0);
        // Frame A: layers 0 and 3 overlap on 5 pixels
        step(0, 4'hF, 4'b0000, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 1);
        repeat (5) step(0, 4'hF, 4'b1001, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 0);
        step(0, 4'hF, 4'b0100, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 0);
        // Frame B without overlap, then its closing latch
        step(0, 4'hF, 4'b0000, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 1);
        repeat (4) step(0, 4'hF, 4'b0010, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 0);
        step(0, 4'hF, 4'b0000, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 1);
        // Overlap of layers 1 and 2 exactly on the frame_start pixel
        step(0, 4'hF, 4'b0000, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 0);
        step(0, 4'hF, 4'b0110, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 1);
        repeat (2) step(0, 4'hF, 4'b0000, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 0);
        step(0, 4'hF, 4'b0000, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 1);
        // Back-to-back frame_start pulses
        step(0, 4'hF, 4'b0011, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 1);
        step(0, 4'hF, 4'b0000, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 1);
        // Blanking and a disabled layer give no hit
        step(0, 4'hF, 4'b0110, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 0, 0);
        step(0, 4'b1101, 4'b0110, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 0);
        step(0, 4'hF, 4'b0011, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 0);
        // Mid-frame reset discards accumulated collisions
        step(1, 4'hF, 4'b0011, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 0);
        step(0, 4'hF, 4'b0000, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 1);
        step(0, 4'hF, 4'b1100, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 1, 0);
        step(0, 4'hF, 4'b0000, pack4(12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0), 12'h010, 0, 1);
        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 4; i++)
                cc[i] = ($urandom_range(0, 5) == 0) ? 12'hFFF : 12'($urandom);
            rr = pack4(cc[0], cc[1], cc[2], cc[3]);
            ee = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            step(($urandom_range(0, 99) == 0), ee, 4'($urandom), rr, 12'($urandom),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
        end
        repeat (3) step(0, 4'hF, 4'b0000, pack4(12'h0, 12'h0, 12'h0, 12'h0), 12'h000, 0, 0);
        for (int k = 0; k < 8 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
